// File: rtl/imem_if.sv
// Fetch-side bus of the instruction-memory responder:
// request, response, flush, boot-load write and busy.
interface imem_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_pc;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_pc;
   logic [31:0] rsp_instr;
   logic        rsp_fault;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;

   modport master (
      output req_valid, req_pc, flush,
      output rsp_ready,
      output wr_en, wr_addr, wr_data,
      input  req_ready, rsp_valid,
      input  rsp_pc, rsp_instr, rsp_fault,
      input  busy
   );

   modport slave (
      input  req_valid, req_pc, flush,
      input  rsp_ready,
      input  wr_en, wr_addr, wr_data,
      output req_ready, rsp_valid,
      output rsp_pc, rsp_instr, rsp_fault,
      output busy
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction RAM responder: fixed-latency read pipeline
// feeding a credit-controlled in-order response FIFO.
module imem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LAT        = 2,
   parameter int FIFO_DEPTH = 4
) (
   input logic   clk,
   input logic   rst,
   imem_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ?
                       $clog2(FIFO_DEPTH) : 1;
   localparam int AW = DEPTH_LOG2;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] ram [2**AW];

   logic [LAT-1:0] s_v;
   logic [31:0]    s_pc  [LAT];
   logic [31:0]    s_ins [LAT];
   logic           s_f   [LAT];

   logic [31:0] f_pc  [FIFO_DEPTH];
   logic [31:0] f_ins [FIFO_DEPTH];
   logic        f_f   [FIFO_DEPTH];

   logic [PW-1:0] wp, rp;
   logic [CW-1:0] fcnt, count;

   logic          accept, pop, push;
   logic          req_fault, wr_ok;
   logic [AW-1:0] rd_idx, wr_idx;
   logic          unused_wr;

   function automatic logic [PW-1:0] nxt(
      input logic [PW-1:0] p
   );
      return (p == PW'(FIFO_DEPTH - 1)) ?
             '0 : p + PW'(1);
   endfunction

   assign req_fault = (bus.req_pc[1:0] != 2'b00) ||
                      (bus.req_pc[31:AW+2] != '0);
   assign rd_idx    = bus.req_pc[AW+1:2];
   assign wr_idx    = bus.wr_addr[AW+1:2];
   assign wr_ok     = (bus.wr_addr[31:AW+2] == '0);
   assign unused_wr = ^bus.wr_addr[1:0];

   // Credits cover pipeline plus FIFO, so a push always fits.
   assign bus.req_ready = !bus.flush &&
                          (count < CW'(FIFO_DEPTH));
   assign accept = bus.req_valid && bus.req_ready;
   assign bus.rsp_valid = !bus.flush && (fcnt != '0);
   assign pop    = bus.rsp_valid && bus.rsp_ready;
   assign push   = s_v[LAT-1];

   assign bus.rsp_pc    = f_pc[rp];
   assign bus.rsp_instr = f_ins[rp];
   assign bus.rsp_fault = f_f[rp];
   assign bus.busy      = (count != '0);

   // Memory is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (bus.wr_en && wr_ok)
         ram[wr_idx] <= bus.wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_v <= '0;
         for (int k = 0; k < LAT; k++) begin
            s_pc[k]  <= '0;
            s_ins[k] <= '0;
            s_f[k]   <= 1'b0;
         end
      end else begin
         if (bus.flush) begin
            s_v <= '0;
         end else begin
            s_v[0] <= accept;
            for (int k = 1; k < LAT; k++)
               s_v[k] <= s_v[k-1];
         end
         s_pc[0]  <= bus.req_pc;
         s_f[0]   <= req_fault;
         s_ins[0] <= req_fault ? NOP : ram[rd_idx];
         for (int k = 1; k < LAT; k++) begin
            s_pc[k]  <= s_pc[k-1];
            s_f[k]   <= s_f[k-1];
            s_ins[k] <= s_ins[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         fcnt  <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            f_pc[i]  <= '0;
            f_ins[i] <= '0;
            f_f[i]   <= 1'b0;
         end
      end else if (bus.flush) begin
         wp    <= '0;
         rp    <= '0;
         fcnt  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            f_pc[wp]  <= s_pc[LAT-1];
            f_ins[wp] <= s_ins[LAT-1];
            f_f[wp]   <= s_f[LAT-1];
            wp        <= nxt(wp);
         end
         if (pop)
            rp <= nxt(rp);
         fcnt  <= fcnt + CW'(push) - CW'(pop);
         count <= count + CW'(accept) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_imem_responder.sv
// Randomised scoreboard bench for imem_responder against
// a queue model of outstanding fetches.
module tb_imem_responder;
   localparam int LAT = 2;
   localparam int FD  = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        flt;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   imem_if bus ();

   imem_responder #(
      .DEPTH_LOG2(10),
      .LAT(LAT),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   exp_t        q[$];
   logic [31:0] mem [1024];
   int          errors = 0;
   int          checks = 0;
   int          now = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] pc);
      exp_t e;
      e.pc  = pc;
      e.flt = (pc[1:0] != 0) || (pc[31:12] != 0);
      e.ins = e.flt ? 32'h13 : mem[pc[11:2]];
      e.acc = now;
      return e;
   endfunction

   task automatic cyc(input logic v,
                      input logic [31:0] pc,
                      input logic fl,
                      input logic rr,
                      input logic we,
                      input logic [31:0] wa,
                      input logic [31:0] wd);
      logic rdy, vld;
      @(negedge clk);
      now++;
      bus.req_valid = v;
      bus.req_pc    = pc;
      bus.flush     = fl;
      bus.rsp_ready = rr;
      bus.wr_en     = we;
      bus.wr_addr   = wa;
      bus.wr_data   = wd;
      #1;
      rdy = !fl && (q.size() < FD);
      vld = !fl && (q.size() != 0) &&
            (q[0].acc + LAT + 1 <= now);
      chk("req_ready", bus.req_ready, rdy);
      chk("busy", bus.busy, q.size() != 0);
      chk("rsp_valid", bus.rsp_valid, vld);
      if (fl) q.delete();
      else if (v && rdy) q.push_back(model(pc));
      if (we && wa[31:12] == 0) mem[wa[11:2]] = wd;
   endtask

   task automatic req(input logic [31:0] pc);
      cyc(1'b1, pc, 1'b0, 1'b1, 1'b0, 0, 0);
   endtask

   task automatic idle(input logic rr);
      cyc(1'b0, 0, 1'b0, rr, 1'b0, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++)
         idle(1'b1);
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic rst_vals(input string tag);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, "_req_ready"}, bus.req_ready, 1);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_rsp_pc"}, bus.rsp_pc, 0);
      chk({tag, "_rsp_instr"}, bus.rsp_instr, 0);
      chk({tag, "_rsp_fault"}, bus.rsp_fault, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
               chk("spurious_rsp", 1, 0);
            end else begin
               e = q.pop_front();
               chk("rsp_pc", bus.rsp_pc, e.pc);
               chk("rsp_instr", bus.rsp_instr, e.ins);
               chk("rsp_fault", bus.rsp_fault, e.flt);
            end
         end
      end
   end

   initial begin : stim
      logic [31:0] pc, wd;
      bus.req_valid = 1'b0;
      bus.req_pc    = '0;
      bus.flush     = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      #2;
      rst_vals("reset");
      @(negedge clk);
      #3 rst = 1'b0;

      for (int i = 0; i < 128; i++) begin
         wd = $urandom;
         if (i == 0) wd = 32'h0050_0093;
         if (i == 1) wd = 32'h0010_0113;
         if (i == 2) wd = 32'h1111_1111;
         cyc(1'b0, 0, 1'b0, 1'b1, 1'b1, i * 4, wd);
      end

      req(32'h0);
      req(32'h4);
      drain();

      for (int i = 0; i < 16; i++) req(i * 4);
      for (int i = 0; i < 4; i++) idle(1'b1);
      drain();

      pc = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, pc, 1'b0, 1'b0, 1'b0, 0, 0);
         if (k < FD) pc += 4;
      end
      drain();

      req(32'h20);
      req(32'h24);
      req(32'h28);
      cyc(1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0);
      req(32'h100);
      drain();

      req(32'h10);
      req(32'h2);
      req(32'h0001_0000);
      req(32'h14);
      drain();

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0: pc = $urandom;
            1: pc = {$urandom_range(0, 127), 2'b01};
            default: pc = {$urandom_range(0, 127), 2'b00};
         endcase
         wd = {$urandom_range(0, 127), 2'b00};
         if ($urandom_range(0, 15) == 0) wd[20] = 1'b1;
         cyc($urandom_range(0, 3) != 0, pc,
             $urandom_range(0, 24) == 0,
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 4) == 0,
             wd, $urandom);
      end
      drain();

      cyc(1'b0, 0, 1'b0, 1'b1, 1'b1, 32'h8, 32'h1111_1111);
      cyc(1'b1, 32'h8, 1'b0, 1'b1,
          1'b1, 32'h8, 32'hDEAD_BEEF);
      cyc(1'b1, 32'h8, 1'b0, 1'b1,
          1'b1, 32'h0001_0008, 32'h0BAD_0BAD);
      req(32'h8);
      drain();

      req(32'h0);
      req(32'h4);
      req(32'h8);
      @(negedge clk);
      bus.req_valid = 1'b0;
      #3 rst = 1'b1;
      q.delete();
      #1;
      rst_vals("midrst");
      idle(1'b1);
      idle(1'b1);
      @(negedge clk);
      #3 rst = 1'b0;
      req(32'h8);
      drain();

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end
endmodule
